// File: rtl/rt_mem_arbiter.sv
// Two-requester Avalon-MM arbiter sharing one 16-bit memory master.
// Optional grant-hold limit: define RT_ARB_STARVE_LIMIT_EN.
module rt_mem_arbiter #(
    parameter int MAX_PEND = 4,
    parameter int HOLD_MAX = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       rq_read,
    input  logic [1:0]       rq_write,
    input  logic [1:0]       rq_lock,
    input  logic [1:0][31:0] rq_address,
    input  logic [1:0][15:0] rq_writedata,
    input  logic [1:0][1:0]  rq_byteenable,
    output logic [1:0]       rq_waitrequest,
    output logic [15:0]      rq_readdata,
    output logic [1:0]       rq_readdatavalid,
    output logic             avm_m0_read,
    output logic             avm_m0_write,
    output logic [31:0]      avm_m0_address,
    output logic [15:0]      avm_m0_writedata,
    output logic [1:0]       avm_m0_byteenable,
    input  logic [15:0]      avm_m0_readdata,
    input  logic             avm_m0_readdatavalid,
    input  logic             avm_m0_waitrequest,
    output logic             o_owner,
    output logic             o_busy,
    output logic             o_err
);

    localparam int PW = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic          err_q, err_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [PW-1:0] pend_dec;

    logic [1:0] req;
    logic       own_rd, own_wr, own_req;
    logic       full, gate_wait, force_rel;
    logic       rd_acc, wr_acc, ret_ok;

`ifdef RT_ARB_STARVE_LIMIT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_q, hold_d;

    // Other side waiting and owner used its budget: revoke the grant
    assign force_rel = (hold_q == HW'(HOLD_MAX)) & req[!owner_q];

    always_comb begin
        hold_d = hold_q;
        if (state_q == S_IDLE && |req) begin
            hold_d = '0;
        end else if ((rd_acc | wr_acc) && hold_q != HW'(HOLD_MAX)) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        req       = rq_read | rq_write | rq_lock;
        own_rd    = rq_read[owner_q];
        own_wr    = rq_write[owner_q] & ~own_rd;
        own_req   = req[owner_q];
        full      = (pend_q == PW'(MAX_PEND));
        gate_wait = avm_m0_waitrequest | (own_rd & full) | force_rel;
        ret_ok    = avm_m0_readdatavalid & (pend_q != '0);
        pend_dec  = pend_q - PW'(ret_ok);

        state_d           = state_q;
        owner_d           = owner_q;
        rr_d              = rr_q;
        rd_acc            = 1'b0;
        wr_acc            = 1'b0;
        rq_waitrequest    = 2'b11;
        avm_m0_read       = 1'b0;
        avm_m0_write      = 1'b0;
        avm_m0_address    = '0;
        avm_m0_writedata  = '0;
        avm_m0_byteenable = '0;
        rq_readdata       = avm_m0_readdata;
        rq_readdatavalid  = 2'b00;
        rq_readdatavalid[owner_q] = ret_ok;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = req[rr_q] ? rr_q : !rr_q;
                    rr_d    = !owner_d;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!own_req || force_rel) begin
                    state_d = (pend_dec == '0) ? S_IDLE : S_DRAIN;
                end else begin
                    rq_waitrequest[owner_q] = gate_wait;
                    // Hold the read off the bus while the return window is full
                    avm_m0_read       = own_rd & ~full;
                    avm_m0_write      = own_wr;
                    avm_m0_address    = rq_address[owner_q];
                    avm_m0_writedata  = rq_writedata[owner_q];
                    avm_m0_byteenable = rq_byteenable[owner_q];
                    rd_acc            = own_rd & ~gate_wait;
                    wr_acc            = own_wr & ~gate_wait;
                end
            end
            S_DRAIN: begin
                if (pend_dec == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case ({rd_acc, ret_ok})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase

        err_d = err_q | (avm_m0_readdatavalid & (pend_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign o_owner = owner_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_err   = err_q;

endmodule

// File: tb/tb_rt_mem_arbiter.sv
// Scoreboard bench for rt_mem_arbiter with a latency-programmable memory.
module tb_rt_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic [1:0]       rq_read = '0, rq_write = '0, rq_lock = '0;
    logic [1:0][31:0] rq_address = '0;
    logic [1:0][15:0] rq_writedata = '0;
    logic [1:0][1:0]  rq_byteenable = '0;
    logic [1:0]       rq_waitrequest, rq_readdatavalid;
    logic [15:0]      rq_readdata;
    logic             avm_m0_read, avm_m0_write;
    logic [31:0]      avm_m0_address;
    logic [15:0]      avm_m0_writedata;
    logic [1:0]       avm_m0_byteenable;
    logic [15:0]      avm_m0_readdata = '0;
    logic             avm_m0_readdatavalid = 1'b0;
    logic             mem_wait = 1'b0;
    logic             o_owner, o_busy, o_err;

    rt_mem_arbiter #(.MAX_PEND(4), .HOLD_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .rq_read(rq_read), .rq_write(rq_write), .rq_lock(rq_lock),
        .rq_address(rq_address), .rq_writedata(rq_writedata),
        .rq_byteenable(rq_byteenable), .rq_waitrequest(rq_waitrequest),
        .rq_readdata(rq_readdata), .rq_readdatavalid(rq_readdatavalid),
        .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
        .avm_m0_address(avm_m0_address), .avm_m0_writedata(avm_m0_writedata),
        .avm_m0_byteenable(avm_m0_byteenable),
        .avm_m0_readdata(avm_m0_readdata),
        .avm_m0_readdatavalid(avm_m0_readdatavalid),
        .avm_m0_waitrequest(mem_wait),
        .o_owner(o_owner), .o_busy(o_busy), .o_err(o_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 2;
    bit force_rdv = 1'b0;
    int outst = 0;
    int max_out = 0;
    int first_ret = -1;
    int acc_cyc = 0;

    typedef struct {
        logic        id;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [15:0] d;
        int          due;
    } mret_t;
    mret_t mq[$];

    function automatic logic [15:0] fdat(input logic [31:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    // Memory model: accepts at negedge, returns lat cycles later
    always @(negedge clk) begin
        if (reset) mq.delete();
        else if (avm_m0_read && !mem_wait)
            mq.push_back('{fdat(avm_m0_address), cyc + lat});
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        avm_m0_readdatavalid = 1'b0;
        if (reset) begin
            avm_m0_readdata = '0;
        end else if (force_rdv) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata = 16'hDEAD;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata = mq[0].d;
            void'(mq.pop_front());
        end
    end

    // Monitor: every returned word must match the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (rq_readdatavalid[i]) begin
                    if (first_ret < 0) first_ret = cyc;
                    outst--;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rdv requester=%0d data=%0h required=none",
                                 i, rq_readdata);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("ret_id", 32'(i), 32'(e.id));
                        chk("ret_data", 32'(rq_readdata), 32'(e.d));
                    end
                end
            end
        end
    end

    always @(posedge clk) if (outst > max_out) max_out = outst;

    task automatic rd(input int id, input logic [31:0] a, input int tmo,
                      input bit must, output bit ok);
        ok = 1'b0;
        rq_read[id] = 1'b1;
        rq_address[id] = a;
        for (int t = 0; t < tmo; t++) begin
            @(negedge clk);
            if (!rq_waitrequest[id]) begin
                exp_q.push_back('{id[0], fdat(a)});
                outst++;
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rq_read[id] = 1'b0;
        if (!ok && must) begin
            checks++;
            failures++;
            $display("FAIL rd_timeout requester=%0d addr=%0h actual=stalled required=accepted",
                     id, a);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
        end
        chk("drain_done", 32'(done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq_read = '0;
        rq_write = '0;
        rq_lock = '0;
        mem_wait = 1'b0;
        force_rdv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        outst = 0;
        max_out = 0;
        first_ret = -1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n0;
        int acc5;
        logic [31:0] a;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait", 32'(rq_waitrequest), 32'h3);
        chk("rst_rdv", 32'(rq_readdatavalid), 32'h0);
        chk("rst_avm", {avm_m0_read, avm_m0_write, 30'd0}, 32'h0);
        chk("rst_addr", avm_m0_address, 32'h0);
        chk("rst_flags", {29'd0, o_owner, o_busy, o_err}, 32'h0);

        // Core 0 full fetch: 12 ray + 2 count + 3x18 triangle reads
        lat = 2;
        do_reset();
        rq_lock[0] = 1'b1;
        for (int k = 0; k < 68; k++) rd(0, 32'h1000 + 32'(2 * k), 50, 1'b1, ok);
        rq_lock[0] = 1'b0;
        wait_drain();
        chk("fetch_err", 32'(o_err), 32'h0);
        chk("fetch_busy", 32'(o_busy), 32'h0);
        chk("fetch_outst", 32'(outst), 32'h0);

        // Contention and round-robin turnaround
        do_reset();
        rq_lock = 2'b11;
        @(negedge clk);
        chk("rr_idle", 32'(o_busy), 32'h0);
        @(negedge clk);
        chk("rr_first", {30'd0, o_owner, o_busy}, 32'h1);
        @(posedge clk);
        #1;
        rd(0, 32'h3000, 20, 1'b1, ok);
        rd(0, 32'h3002, 20, 1'b1, ok);
        wait_drain();
        rq_lock[0] = 1'b0;
        @(negedge clk);
        chk("rr_rel0", {30'd0, o_owner, o_busy}, 32'h1);
        @(negedge clk);
        chk("rr_rel1", 32'(o_busy), 32'h0);
        @(negedge clk);
        chk("rr_second", {30'd0, o_owner, o_busy}, 32'h3);
        rq_lock[0] = 1'b1;
        @(posedge clk);
        #1;
        rd(1, 32'h3100, 20, 1'b1, ok);
        chk("rr_nonown_wait", 32'(rq_waitrequest[0]), 32'h1);
        wait_drain();
        rq_lock[1] = 1'b0;
        @(posedge clk);
        #1;
        rq_lock[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rr_third", {30'd0, o_owner, o_busy}, 32'h1);

        // Memory stall for 5 cycles mid-sequence
        do_reset();
        rq_lock[0] = 1'b1;
        fork
            begin
                for (int k = 0; k < 10; k++)
                    rd(0, 32'h2000 + 32'(2 * k), 50, 1'b1, ok);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                mem_wait = 1'b1;
                a = avm_m0_address;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_wait", 32'(rq_waitrequest[0]), 32'h1);
                    chk("stall_rd", 32'(avm_m0_read), 32'h1);
                    if (s > 0) chk("stall_addr", avm_m0_address, a);
                    a = avm_m0_address;
                end
                @(posedge clk);
                #1;
                mem_wait = 1'b0;
            end
        join
        rq_lock[0] = 1'b0;
        wait_drain();

        // Pending limit with 10-cycle memory latency
        lat = 10;
        do_reset();
        rq_lock[0] = 1'b1;
        acc5 = 0;
        for (int k = 0; k < 6; k++) begin
            rd(0, 32'h4000 + 32'(2 * k), 100, 1'b1, ok);
            if (k == 4) acc5 = acc_cyc;
        end
        rq_lock[0] = 1'b0;
        wait_drain();
        chk("pend_max", 32'(max_out), 32'd4);
        chk("pend_5th_after_ret", 32'(acc5 > first_ret), 32'h1);

        // Spurious return in IDLE
        lat = 2;
        do_reset();
        @(negedge clk);
        force_rdv = 1'b1;
        @(posedge clk);
        #2;
        force_rdv = 1'b0;
        @(negedge clk);
        chk("spur_rdv", 32'(rq_readdatavalid), 32'h0);
        @(negedge clk);
        chk("spur_err", 32'(o_err), 32'h1);
        repeat (3) @(negedge clk);
        chk("spur_err_sticky", 32'(o_err), 32'h1);

        // Reset during DRAIN with three reads outstanding
        lat = 10;
        @(posedge clk);
        #1;
        rq_lock[1] = 1'b1;
        for (int k = 0; k < 3; k++) rd(1, 32'h5000 + 32'(2 * k), 20, 1'b1, ok);
        rq_lock[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drain_state", {30'd0, o_owner, o_busy}, 32'h3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_wait", 32'(rq_waitrequest), 32'h3);
        chk("mrst_flags", {29'd0, o_owner, o_busy, o_err}, 32'h0);
        chk("mrst_avm", {avm_m0_read, avm_m0_write, 30'd0}, 32'h0);
        chk("mrst_rdv", 32'(rq_readdatavalid), 32'h0);
        exp_q.delete();
        outst = 0;

        // Grant-hold limit with core 0 locked and core 1 waiting
        lat = 2;
        do_reset();
        rq_lock = 2'b11;
        n0 = 0;
`ifdef RT_ARB_STARVE_LIMIT_EN
        for (int k = 0; k < 12; k++) begin
            rd(0, 32'h6000 + 32'(2 * k), 20, 1'b0, ok);
            if (!ok) break;
            n0++;
        end
        chk("starve_count", 32'(n0), 32'd8);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (o_owner && o_busy) break;
        end
        chk("starve_owner", 32'(o_owner), 32'h1);
        rq_lock[0] = 1'b0;
`else
        for (int k = 0; k < 12; k++) begin
            rd(0, 32'h6000 + 32'(2 * k), 20, 1'b1, ok);
            if (ok) n0++;
        end
        chk("hold_count", 32'(n0), 32'd12);
        @(negedge clk);
        chk("hold_owner", {30'd0, o_owner, rq_waitrequest[1]}, 32'h1);
        @(posedge clk);
        #1;
        rq_lock[0] = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (o_owner && o_busy) break;
        end
        chk("hold_owner_after", 32'(o_owner), 32'h1);
`endif
        @(posedge clk);
        #1;
        rd(1, 32'h6100, 20, 1'b1, ok);
        rq_lock = 2'b00;
        wait_drain();
        chk("end_err", 32'(o_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
